// File: rtl/ebus_driver_mux_if.sv
// EBUS driver-mux bundle: per-source drive requests and data in, registered EBUS data and contention log out.
// The master side drives the requests; the slave side is the mux.
interface ebus_driver_mux_if #(
   parameter int NSRC  = 13,
   parameter int W     = 36,
   parameter int IDW   = 5,
   parameter int CNT_W = 8
);
   logic [NSRC-1:0]   driving;
   logic [NSRC*W-1:0] srcData;
   logic              clrErr;
   logic [W-1:0]      data;
   logic              valid;
   logic [IDW-1:0]    srcId;
   logic              conflict;
   logic              conflictSticky;
   logic [CNT_W-1:0]  conflictCnt;
   logic [NSRC-1:0]   lastConflictMask;

   modport master (
      output driving, srcData, clrErr,
      input  data, valid, srcId, conflict, conflictSticky, conflictCnt, lastConflictMask
   );

   modport slave (
      input  driving, srcData, clrErr,
      output data, valid, srcId, conflict, conflictSticky, conflictCnt, lastConflictMask
   );
endinterface

// File: rtl/ebus_driver_mux.sv
// Registered EBUS data mux with fixed-priority or round-robin selection and contention logging.
// One clk from driving/srcData to every output; no backpressure, a request is served the cycle it is presented.
module ebus_driver_mux #(
   parameter int NSRC    = 13,
   parameter int W       = 36,
   parameter int RR_MODE = 0,
   parameter int CNT_W   = 8,
   parameter int IDW     = 5
) (
   input logic              clk,
   input logic              CROBAR,
   ebus_driver_mux_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   generate
      if (NSRC < 2) begin : g_bad_nsrc
         $error("ebus_driver_mux: NSRC must be at least 2");
      end
      if ((1 << IDW) < NSRC) begin : g_bad_idw
         $error("ebus_driver_mux: IDW too narrow to index NSRC sources");
      end
   endgenerate

   // First asserted request at or above start, wrapping modulo NSRC.
   function automatic logic [IDW-1:0] pick(input logic [NSRC-1:0] req, input logic [IDW-1:0] start);
      logic [IDW-1:0] sel;
      logic           found;
      int             idx;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NSRC; k++) begin
         idx = int'(start) + k;
         if (idx >= NSRC) idx = idx - NSRC;
         if (!found && req[idx]) begin
            sel   = IDW'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   logic [W-1:0]     data_q, data_d;
   logic             valid_q, valid_d;
   logic [IDW-1:0]   src_id_q, src_id_d;
   logic             conflict_q, conflict_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NSRC-1:0]  mask_q, mask_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

   logic             any_drv;
   logic             multi_drv;
   logic [IDW-1:0]   win_id;

   always_comb begin
      any_drv    = |bus.driving;
      multi_drv  = $countones(bus.driving) > 1;
      win_id     = pick(bus.driving, (RR_MODE != 0) ? rr_ptr_q : '0);

      data_d     = '0;
      valid_d    = any_drv;
      src_id_d   = src_id_q;
      conflict_d = multi_drv;
      sticky_d   = sticky_q;
      cnt_d      = cnt_q;
      mask_d     = mask_q;
      rr_ptr_d   = rr_ptr_q;

      // The winner's data alone reaches the bus even under contention.
      if (any_drv) begin
         data_d   = bus.srcData[int'(win_id)*W +: W];
         src_id_d = win_id;
         rr_ptr_d = (int'(win_id) == NSRC-1) ? '0 : win_id + 1'b1;
      end

      if (clrErr_active()) begin
         sticky_d = 1'b0;
         cnt_d    = '0;
      end

      // Contention in the same cycle as a clear is logged on top of the cleared state.
      if (multi_drv) begin
         sticky_d = 1'b1;
         mask_d   = bus.driving;
         if (bus.clrErr)
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
         else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
      end
   end

   function automatic logic clrErr_active();
      return bus.clrErr;
   endfunction

   always_ff @(posedge clk) begin
      if (CROBAR) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         src_id_q   <= '0;
         conflict_q <= 1'b0;
         sticky_q   <= 1'b0;
         cnt_q      <= '0;
         mask_q     <= '0;
         rr_ptr_q   <= '0;
      end else begin
         data_q     <= data_d;
         valid_q    <= valid_d;
         src_id_q   <= src_id_d;
         conflict_q <= conflict_d;
         sticky_q   <= sticky_d;
         cnt_q      <= cnt_d;
         mask_q     <= mask_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   always @(posedge clk) begin
      if (!CROBAR && multi_drv)
         $warning("ebus_driver_mux: contention, driving=%h", bus.driving);
   end

   assign bus.data             = data_q;
   assign bus.valid            = valid_q;
   assign bus.srcId            = src_id_q;
   assign bus.conflict         = conflict_q;
   assign bus.conflictSticky   = sticky_q;
   assign bus.conflictCnt      = cnt_q;
   assign bus.lastConflictMask = mask_q;

endmodule

// File: tb/tb_ebus_driver_mux.sv
// Bench for ebus_driver_mux: fixed-priority, round-robin and narrow-counter instances,
// directed vectors with a cycle-tagged scoreboard per instance.
module tb_ebus_driver_mux;

   typedef struct {
      int          due;
      logic [35:0] data;
      logic        valid;
      logic [4:0]  id;
      logic        conflict;
      logic        sticky;
      logic [7:0]  cnt;
      logic [12:0] mask;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   exp_t qf[$];
   exp_t qr[$];
   exp_t qc[$];
   exp_t af, ar, ac;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ebus_driver_mux_if #(.NSRC(13), .W(36), .IDW(5), .CNT_W(8)) bf ();
   ebus_driver_mux_if #(.NSRC(13), .W(36), .IDW(5), .CNT_W(8)) br ();
   ebus_driver_mux_if #(.NSRC(13), .W(36), .IDW(5), .CNT_W(2)) bc ();

   ebus_driver_mux #(.NSRC(13), .W(36), .RR_MODE(0), .CNT_W(8), .IDW(5)) u_fp (
      .clk(clk), .CROBAR(rst), .bus(bf));
   ebus_driver_mux #(.NSRC(13), .W(36), .RR_MODE(1), .CNT_W(8), .IDW(5)) u_rr (
      .clk(clk), .CROBAR(rst), .bus(br));
   ebus_driver_mux #(.NSRC(13), .W(36), .RR_MODE(0), .CNT_W(2), .IDW(5)) u_c2 (
      .clk(clk), .CROBAR(rst), .bus(bc));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, want);
      end
   endtask

   task automatic cmp(input string tag, input exp_t e, input exp_t a);
      chk({tag, ".data"},     64'(a.data),     64'(e.data));
      chk({tag, ".valid"},    64'(a.valid),    64'(e.valid));
      chk({tag, ".srcId"},    64'(a.id),       64'(e.id));
      chk({tag, ".conflict"}, 64'(a.conflict), 64'(e.conflict));
      chk({tag, ".sticky"},   64'(a.sticky),   64'(e.sticky));
      chk({tag, ".cnt"},      64'(a.cnt),      64'(e.cnt));
      chk({tag, ".mask"},     64'(a.mask),     64'(e.mask));
   endtask

   function automatic exp_t ex(input logic [35:0] d, input logic v, input logic [4:0] id,
                               input logic c, input logic s, input logic [7:0] n, input logic [12:0] m);
      exp_t e;
      e.due      = cyc + 1;
      e.data     = d;
      e.valid    = v;
      e.id       = id;
      e.conflict = c;
      e.sticky   = s;
      e.cnt      = n;
      e.mask     = m;
      return e;
   endfunction

   function automatic exp_t ex_zero();
      return ex('0, 1'b0, 5'd0, 1'b0, 1'b0, 8'd0, 13'h0);
   endfunction

   // Monitors: each pops the expectations due this cycle and compares against the DUT.
   always @(negedge clk) begin
      while (qf.size() > 0 && qf[0].due <= cyc) begin
         af.due = cyc; af.data = bf.data; af.valid = bf.valid; af.id = bf.srcId;
         af.conflict = bf.conflict; af.sticky = bf.conflictSticky;
         af.cnt = bf.conflictCnt; af.mask = bf.lastConflictMask;
         cmp("fp", qf.pop_front(), af);
      end
      while (qr.size() > 0 && qr[0].due <= cyc) begin
         ar.due = cyc; ar.data = br.data; ar.valid = br.valid; ar.id = br.srcId;
         ar.conflict = br.conflict; ar.sticky = br.conflictSticky;
         ar.cnt = br.conflictCnt; ar.mask = br.lastConflictMask;
         cmp("rr", qr.pop_front(), ar);
      end
      while (qc.size() > 0 && qc[0].due <= cyc) begin
         ac.due = cyc; ac.data = bc.data; ac.valid = bc.valid; ac.id = bc.srcId;
         ac.conflict = bc.conflict; ac.sticky = bc.conflictSticky;
         ac.cnt = 8'(bc.conflictCnt); ac.mask = bc.lastConflictMask;
         cmp("c2", qc.pop_front(), ac);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bf.driving = '0; bf.clrErr = 1'b0; bf.srcData = '0;
      br.driving = '0; br.clrErr = 1'b0; br.srcData = '0;
      bc.driving = '0; bc.clrErr = 1'b0; bc.srcData = '0;
      for (int i = 0; i < 13; i++) bf.srcData[i*36 +: 36] = 36'o100 + 36'(i);
      bf.driving = 13'h1FFF;

      // Reset with every source requesting: all outputs held at zero.
      for (int i = 0; i < 3; i++) begin
         tick();
         qf.push_back(ex_zero()); qr.push_back(ex_zero()); qc.push_back(ex_zero());
      end
      tick(); rst = 1'b0;
      qf.push_back(ex(36'o100, 1'b1, 5'd0, 1'b1, 1'b1, 8'd1, 13'h1FFF));
      qr.push_back(ex_zero()); qc.push_back(ex_zero());

      // Fixed priority.
      tick(); bf.driving = 13'h024;
      bf.srcData[2*36 +: 36] = 36'o123; bf.srcData[5*36 +: 36] = 36'o777;
      qf.push_back(ex(36'o123, 1'b1, 5'd2, 1'b1, 1'b1, 8'd2, 13'h024));
      tick(); bf.driving = 13'h200; bf.srcData[9*36 +: 36] = 36'o400000000000;
      qf.push_back(ex(36'o400000000000, 1'b1, 5'd9, 1'b0, 1'b1, 8'd2, 13'h024));
      tick(); bf.driving = 13'h000;
      qf.push_back(ex(36'o0, 1'b0, 5'd9, 1'b0, 1'b1, 8'd2, 13'h024));
      tick(); bf.clrErr = 1'b1;
      qf.push_back(ex(36'o0, 1'b0, 5'd9, 1'b0, 1'b0, 8'd0, 13'h024));
      tick(); bf.clrErr = 1'b0; bf.driving = 13'h088;
      qf.push_back(ex(36'o103, 1'b1, 5'd3, 1'b1, 1'b1, 8'd1, 13'h088));
      tick(); bf.driving = 13'h000;
      qf.push_back(ex(36'o0, 1'b0, 5'd3, 1'b0, 1'b1, 8'd1, 13'h088));

      // Round robin, then pointer wrap from 12.
      br.srcData[0*36 +: 36]  = 36'o1000; br.srcData[2*36 +: 36]  = 36'o222;
      br.srcData[5*36 +: 36]  = 36'o555;  br.srcData[11*36 +: 36] = 36'o1111;
      br.srcData[12*36 +: 36] = 36'o1212;
      tick(); br.driving = 13'h024;
      qr.push_back(ex(36'o222, 1'b1, 5'd2, 1'b1, 1'b1, 8'd1, 13'h024));
      tick();
      qr.push_back(ex(36'o555, 1'b1, 5'd5, 1'b1, 1'b1, 8'd2, 13'h024));
      tick();
      qr.push_back(ex(36'o222, 1'b1, 5'd2, 1'b1, 1'b1, 8'd3, 13'h024));
      tick();
      qr.push_back(ex(36'o555, 1'b1, 5'd5, 1'b1, 1'b1, 8'd4, 13'h024));
      tick(); br.driving = 13'h0800;
      qr.push_back(ex(36'o1111, 1'b1, 5'd11, 1'b0, 1'b1, 8'd4, 13'h024));
      tick(); br.driving = 13'h1001;
      qr.push_back(ex(36'o1212, 1'b1, 5'd12, 1'b1, 1'b1, 8'd5, 13'h1001));
      tick();
      qr.push_back(ex(36'o1000, 1'b1, 5'd0, 1'b1, 1'b1, 8'd6, 13'h1001));
      tick(); br.driving = 13'h000;
      qr.push_back(ex(36'o0, 1'b0, 5'd0, 1'b0, 1'b1, 8'd6, 13'h1001));

      // Two-bit counter saturation and clear interplay.
      bc.srcData[1*36 +: 36] = 36'o11; bc.srcData[4*36 +: 36] = 36'o44;
      tick(); bc.driving = 13'h012;
      qc.push_back(ex(36'o11, 1'b1, 5'd1, 1'b1, 1'b1, 8'd1, 13'h012));
      tick();
      qc.push_back(ex(36'o11, 1'b1, 5'd1, 1'b1, 1'b1, 8'd2, 13'h012));
      tick();
      qc.push_back(ex(36'o11, 1'b1, 5'd1, 1'b1, 1'b1, 8'd3, 13'h012));
      tick();
      qc.push_back(ex(36'o11, 1'b1, 5'd1, 1'b1, 1'b1, 8'd3, 13'h012));
      tick();
      qc.push_back(ex(36'o11, 1'b1, 5'd1, 1'b1, 1'b1, 8'd3, 13'h012));
      tick(); bc.driving = 13'h000; bc.clrErr = 1'b1;
      qc.push_back(ex(36'o0, 1'b0, 5'd1, 1'b0, 1'b0, 8'd0, 13'h012));
      tick(); bc.driving = 13'h012;
      qc.push_back(ex(36'o11, 1'b1, 5'd1, 1'b1, 1'b1, 8'd1, 13'h012));
      tick(); bc.driving = 13'h000; bc.clrErr = 1'b0;
      qc.push_back(ex(36'o0, 1'b0, 5'd1, 1'b0, 1'b1, 8'd1, 13'h012));

      for (int i = 0; i < 3; i++) tick();
      total++;
      if (qf.size() + qr.size() + qc.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations never checked, want 0", qf.size() + qr.size() + qc.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
